// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state codes and GF(2^8) byte helpers.
// The S-box is computed as inverse-then-affine so one function serves every lookup site.
package aes_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned NR    = 10;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] rk_i,
  input  logic [7:0]       rcon_i,
  output logic [BLK_W-1:0] rk_o
);

  logic [31:0] t;
  logic [31:0] w0, w1, w2, w3;

  // RotWord then SubWord on the last word of the current key.
  assign t = {sbox(rk_i[23:16]), sbox(rk_i[15:8]), sbox(rk_i[7:0]), sbox(rk_i[31:24])}
             ^ {rcon_i, 24'h000000};

  assign w0 = rk_i[127:96] ^ t;
  assign w1 = rk_i[95:64]  ^ w0;
  assign w2 = rk_i[63:32]  ^ w1;
  assign w3 = rk_i[31:0]   ^ w2;

  assign rk_o = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes stage: sixteen parallel S-box lookups over the 128-bit state.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] data_i,
  output logic [BLK_W-1:0] data_o
);

  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign data_o[8*b +: 8] = sbox(data_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-128 encryption controller: one round per clock over a single state register,
// round keys generated on the fly, one block in flight with valid/ready on both sides.
module aes_round_controller #(
  parameter int unsigned NR    = aes_pkg::NR,
  parameter int unsigned BLK_W = aes_pkg::BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] plaintext,
  input  logic [BLK_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] ciphertext,
  output logic             busy,
  output logic [3:0]       round,
  output logic [BLK_W-1:0] dbg_state
);
  import aes_pkg::*;

  // Byte i of a block sits at bits [127-8i -: 8]; byte index = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [1:0]       st_q, st_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [BLK_W-1:0] rk_q, rk_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic [3:0]       round_q, round_d;

  logic [BLK_W-1:0] sb, sr, mc, rk_next;

  aes_sub_bytes u_sub_bytes (
    .data_i (state_q),
    .data_o (sb)
  );

  aes_key_step u_key_step (
    .rk_i   (rk_q),
    .rcon_i (rcon(round_q)),
    .rk_o   (rk_next)
  );

  assign sr = shift_rows(sb);
  assign mc = mix_columns(sr);

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    round_d = round_q;
    case (st_q)
      StIdle: begin
        if (in_valid) begin
          state_d = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
          st_d    = StRound;
        end
      end
      StRound: begin
        rk_d = rk_next;
        if (round_q == 4'(NR)) begin
          // Final round skips MixColumns and latches the result for the host.
          state_d = sr ^ rk_next;
          ct_d    = sr ^ rk_next;
          st_d    = StDone;
        end else begin
          state_d = mc ^ rk_next;
          round_d = round_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          round_d = 4'd0;
          st_d    = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      state_q <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      round_q <= 4'd0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      round_q <= round_d;
    end
  end

  assign in_ready   = (st_q == StIdle);
  assign busy       = (st_q == StRound);
  assign out_valid  = (st_q == StDone);
  assign ciphertext = ct_q;
  assign round      = round_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: protocol-level model with known-answer lookup, checked every
// cycle, plus directed FIPS-197 vectors with literal expectations.
module tb_aes_round_controller;

  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;
  logic [127:0] dbg_state;

  int tests = 0;
  int fails = 0;

  aes_round_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Known-answer table stands in for the cipher itself.
  function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [127:0] k);
    if (pt == PtB && k == KeyB) return CtB;
    if (pt == PtC && k == KeyC) return CtC;
    return 'x;
  endfunction

  // Protocol model: a block occupies 10 edges of work after acceptance, then waits for out_ready.
  bit           m_live = 0;
  bit           m_inflight = 0;
  bit           m_ov = 0;
  bit           m_dbg_zero = 0;
  int           m_round = 0;
  logic [127:0] m_exp = '0;
  logic [127:0] m_ct = '0;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_out = 0;
  int           acc_cyc [8];
  logic [127:0] out_log [8];

  always @(posedge clk) begin
    m_live <= 1'b1;
    cyc    <= cyc + 1;
    if (!rst_n) begin
      m_inflight <= 1'b0;
      m_ov       <= 1'b0;
      m_round    <= 0;
      m_ct       <= '0;
      m_dbg_zero <= 1'b1;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov           <= 1'b0;
        m_round        <= 0;
        out_log[n_out] <= ciphertext;
        n_out          <= n_out + 1;
      end
    end else if (m_inflight) begin
      if (m_round == 10) begin
        m_inflight <= 1'b0;
        m_ov       <= 1'b1;
        m_ct       <= m_exp;
      end else begin
        m_round <= m_round + 1;
      end
    end else if (in_valid) begin
      m_inflight     <= 1'b1;
      m_round        <= 1;
      m_exp          <= ref_ct(plaintext, key);
      m_dbg_zero     <= 1'b0;
      acc_cyc[n_acc] <= cyc;
      n_acc          <= n_acc + 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", {127'd0, in_ready}, {127'd0, !m_inflight && !m_ov});
      chk("out_valid", {127'd0, out_valid}, {127'd0, m_ov});
      chk("busy", {127'd0, busy}, {127'd0, m_inflight});
      chk("round", {124'd0, round}, 128'(m_round));
      chk("ciphertext", ciphertext, m_ct);
      if (m_ov) chk("dbg_state_done", dbg_state, m_ct);
      if (m_dbg_zero) chk("dbg_state_zero", dbg_state, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    step();
    step();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_round", {124'd0, round}, 128'd0);
    chk("rst_dbg_state", dbg_state, 128'd0);
    chk("rst_ciphertext", ciphertext, 128'd0);
    rst_n = 1'b1;
    step();

    // App. B with intermediate states, busy rejection during rounds 3..5.
    plaintext = PtB;
    key       = KeyB;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("b_accept_state", dbg_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    step();
    chk("b_edge1_state", dbg_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    step();
    chk("b_edge2_state", dbg_state, 128'haa8f5f0361dde3ef82d24ad26832469a);
    plaintext = PtC;
    key       = KeyC;
    in_valid  = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("b_edge9_not_valid", {127'd0, out_valid}, 128'd0);
    step();
    chk("b_edge10_valid", {127'd0, out_valid}, 128'd1);
    chk("b_ciphertext", ciphertext, CtB);

    // Backpressure: hold for 20 cycles, then one handshake.
    repeat (20) step();
    chk("bp_still_valid", {127'd0, out_valid}, 128'd1);
    chk("bp_ciphertext", ciphertext, CtB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ready", {127'd0, in_ready}, 128'd1);
    chk("bp_idle_round", {124'd0, round}, 128'd0);

    // Reset at round 6, then App. C.1.
    plaintext = PtB;
    key       = KeyB;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("mid_round6", {124'd0, round}, 128'd6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_round", {124'd0, round}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_dbg_state", dbg_state, 128'd0);
    plaintext = PtC;
    key       = KeyC;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("c_edge9_not_valid", {127'd0, out_valid}, 128'd0);
    step();
    wait_out_valid(5);
    chk("c_ciphertext", ciphertext, CtC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Back-to-back with in_valid and out_ready held high.
    begin
      int base_acc;
      int base_out;
      int n;
      base_acc  = n_acc;
      base_out  = n_out;
      plaintext = PtB;
      key       = KeyB;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (n_acc == base_acc && n < 5) begin step(); n++; end
      plaintext = PtC;
      key       = KeyC;
      n = 0;
      while (n_acc == base_acc + 1 && n < 30) begin step(); n++; end
      in_valid = 1'b0;
      n = 0;
      while (n_out < base_out + 2 && n < 30) begin step(); n++; end
      out_ready = 1'b0;
      chk("b2b_accepts", 128'(n_acc - base_acc), 128'd2);
      chk("b2b_outputs", 128'(n_out - base_out), 128'd2);
      chk("b2b_spacing", 128'(acc_cyc[base_acc + 1] - acc_cyc[base_acc]), 128'd12);
      chk("b2b_first_ct", out_log[base_out], CtB);
      chk("b2b_second_ct", out_log[base_out + 1], CtC);
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_controller.md
Name: aes_round_controller

Overview:
- Iterative AES-128 encryption engine controller; one round per clock.
- Sequences the existing combinational SubBytes, ShiftRows, MixColumns and AddRoundKey stages over a single 128-bit state register.
- Generates round keys on the fly.
- Sits between the host-side block interface (valid/ready) and the round datapath; one block in flight at a time.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; any other value is unsupported).
- BLK_W, 128, state/key/block width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  plaintext and key present
- in_ready  out  1  controller can accept a block
- plaintext  in  128  input block, FIPS-197 byte order (byte 0 = bits 127:120)
- key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- ciphertext  out  128  result block
- busy  out  1  high in ROUND state
- round  out  4  current round index, 0 in IDLE
- dbg_state  out  128  live state register, for verification

Behaviour:
- Reset (rst_n low at a clock edge):
  - state IDLE; in_ready=1; out_valid=0; busy=0; round=0.
  - ciphertext, dbg_state and round key cleared to 0.
  - Applies from any state: an in-flight block is discarded with no output; a pending out_valid is dropped.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state <= plaintext^key; rk <= key; round <= 1; go to ROUND.
- ROUND, rounds 1..9, one per edge:
  - state <= MixColumns(ShiftRows(SubBytes(state)))^rk_next; rk <= rk_next; round++.
  - rk_next = key_step(rk, RCON[round-1]).
- ROUND, round 10:
  - state <= ShiftRows(SubBytes(state))^rk_next (no MixColumns).
  - ciphertext <= that value; out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1; ciphertext and dbg_state held stable until out_ready.
  - On out_valid&&out_ready: out_valid <= 0; round <= 0; go to IDLE.
  - in_ready stays 0 in DONE, so a new block is first accepted on the cycle after the output handshake. No overlap, no bypass.
- Latency: out_valid is visible immediately after the 10th rising edge following the accepting edge. Throughput is one block per 12 cycles with out_ready held high.
- in_ready=0 in ROUND and DONE. plaintext and key are sampled only on the accepting edge; later changes are ignored.
- Reset and handshake in the same cycle: reset wins; the block is not accepted.
- out_ready asserted when out_valid=0: ignored.
- busy=1 exactly in ROUND; round reads 1..10 during ROUND and 10 in DONE.
- key_step(w, rc):
  - t = SubWord(RotWord(w[31:0])) ^ {rc,24'h0}.
  - w0' = w[127:96]^t; w1' = w[95:64]^w0'; w2' = w[63:32]^w1'; w3' = w[31:0]^w2'.
- All XOR/byte operations are in GF(2^8), bitwise, with no carries.

Decomposition:
- aes_pkg holds:
  - RCON table: 01,02,04,08,10,20,40,80,1b,36.
  - FSM state enum (IDLE, ROUND, DONE).
  - BLK_W and NR constants.
  - Shared S-box byte function used by both SubBytes and key_step.
- One sub-module: aes_key_step (combinational, 128-bit rk plus 8-bit rcon in, next rk out), containing its own four S-box lookups.
- The existing SubBytes module is instantiated unchanged for the state path; the key path does not share it.

Test Plan:
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c:
  - After the accepting edge, dbg_state=193de3bea0f4e22b9ac68d2ae9f84808.
  - After edge 1, dbg_state=a49c7ff2689f352b6b5bea43026a5049.
  - After edge 2, dbg_state=aa8f5f0361dde3ef82d24ad26832469a.
  - After edge 10, out_valid=1 and ciphertext=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, 10 edges after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles after App. B completes -> out_valid and ciphertext stable, in_ready=0 throughout. On out_ready=1 -> one handshake, then IDLE with in_ready=1 on the next cycle.
- Busy rejection: change plaintext and key and pulse in_valid during rounds 3..5 -> ignored; output is still the App. B ciphertext.
- Reset mid-operation: rst_n=0 for one edge at round 6 -> next cycle out_valid=0, round=0, in_ready=1, dbg_state=0. A following App. C.1 block then produces 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: App. B then App. C.1 with in_valid and out_ready held high -> two correct outputs, second accepted exactly 12 cycles after the first.
